// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_ctrl_pkg                                                         |
// | Shared types and constants for the HD44780 timed bus controller.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package lcd_ctrl_pkg;

  // Panel access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_e;

  // Kind of access requested by the bus master
  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } lcd_op_e;

  // Panel pin encodings used for the busy-flag status read
  localparam logic RW_READ = 1'b1;
  localparam logic RS_CMD  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_phase_timer                                                      |
// | Loadable down-counter; expire is high while the count equals 1, so   |
// | a phase loaded with N lasts exactly N cycles.                        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module lcd_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over counting; the counter parks at zero when not reloaded
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hd44780_ctrl                                                     |
// | Avalon-MM slave that turns each access into a timed HD44780 E-strobe |
// | cycle (setup / pulse / hold), 8-bit or 4-bit panel bus, with an      |
// | optional busy-flag poll after every write.                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module lcd_hd44780_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int BUS_W     = 8,
  parameter int T_AS      = 2,
  parameter int T_PW      = 12,
  parameter int T_H       = 2,
  parameter int AUTO_BUSY = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  inout  wire  [BUS_W-1:0] LCD_data
);

  localparam logic [CNT_W-1:0] LD_AS = CNT_W'(T_AS);
  localparam logic [CNT_W-1:0] LD_PW = CNT_W'(T_PW);
  localparam logic [CNT_W-1:0] LD_H  = CNT_W'(T_H);

  lcd_state_e       state_q, state_d;
  lcd_op_e          op_q, op_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             e_q, e_d;
  logic             nib_q, nib_d;
  logic             poll_q, poll_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       samp_q, samp_d;
  logic [7:0]       readdata_q, readdata_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expire;

  logic [BUS_W-1:0] dout_w;
  logic [7:0]       samp_next_w;
  logic             drive_w;

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  // Bus-width specific data steering: 4-bit panels move the high nibble first
  generate
    if (BUS_W == 4) begin : g_bus4
      assign dout_w      = nib_q ? wdata_q[3:0] : wdata_q[7:4];
      assign samp_next_w = nib_q ? {samp_q[7:4], LCD_data} : {LCD_data, samp_q[3:0]};
    end else begin : g_bus8
      assign dout_w      = wdata_q;
      assign samp_next_w = LCD_data;
    end
  endgenerate

  // Sequencer next-state logic; each phase reloads the shared timer on entry
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    nib_d      = nib_q;
    poll_d     = poll_q;
    wdata_d    = wdata_q;
    samp_d     = samp_q;
    readdata_d = readdata_q;
    tmr_load   = 1'b0;
    tmr_value  = LD_AS;

    case (state_q)
      ST_IDLE: begin
        if (read || write) begin
          // Read wins when both requests are present
          state_d  = ST_SETUP;
          op_d     = read ? OP_READ : OP_WRITE;
          rs_d     = address[1];
          rw_d     = read ? RW_READ : address[0];
          wdata_d  = writedata;
          nib_d    = 1'b0;
          poll_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          state_d   = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = LD_PW;
        end
      end
      ST_PULSE: begin
        if (tmr_expire) begin
          // Panel read data is valid at the end of the E-high window
          samp_d    = samp_next_w;
          state_d   = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_value = LD_H;
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          if ((BUS_W == 4) && !nib_q) begin
            nib_d    = 1'b1;
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
          end else if ((AUTO_BUSY != 0) && (op_q == OP_WRITE) && !poll_q) begin
            rs_d     = RS_CMD;
            rw_d     = RW_READ;
            poll_d   = 1'b1;
            nib_d    = 1'b0;
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
          end else if (poll_q && samp_q[7]) begin
            nib_d    = 1'b0;
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
          end else begin
            // Status polls never disturb the user-visible read register
            if (op_q == OP_READ) begin
              readdata_d = samp_q;
            end
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // E is registered from the next state so it never glitches
    e_d = (state_d == ST_PULSE);
  end

  // State and datapath registers; reset abandons any panel cycle at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      e_q        <= 1'b0;
      nib_q      <= 1'b0;
      poll_q     <= 1'b0;
      wdata_q    <= 8'h00;
      samp_q     <= 8'h00;
      readdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      e_q        <= e_d;
      nib_q      <= nib_d;
      poll_q     <= poll_d;
      wdata_q    <= wdata_d;
      samp_q     <= samp_d;
      readdata_q <= readdata_d;
    end
  end

  assign drive_w = !rw_q && ((state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                             (state_q == ST_HOLD));

  assign LCD_data    = drive_w ? dout_w : {BUS_W{1'bz}};
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;
  assign readdata    = readdata_q;
  assign waitrequest = (read || write) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_hd44780_ctrl                                                  |
// | Three controller configurations against a cycle-level access model  |
// | and a panel model that answers reads and otherwise holds the bus low.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_lcd_hd44780_ctrl;

  localparam int ND = 3;

  typedef struct packed {
    logic       e;
    logic       chk;
    logic       rs;
    logic       rw;
    logic       drv;
    logic       busy;
    logic       done;
    logic [7:0] val;
    logic [7:0] pan;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] addr  [ND];
  logic       rd    [ND];
  logic       wr    [ND];
  logic [7:0] wd    [ND];
  logic [7:0] rdata [ND];
  logic       wreq  [ND];
  logic       e     [ND];
  logic       rs    [ND];
  logic       rw    [ND];
  logic       pen   [ND];
  logic [7:0] pval  [ND];
  logic [7:0] busv  [ND];
  wire  [7:0] bus0;
  wire  [3:0] bus1;
  wire  [7:0] bus2;

  // Access model state
  bit         m_act   [ND];
  int         m_start [ND];
  bit         m_read  [ND];
  logic [1:0] m_addr  [ND];
  logic [7:0] m_wd    [ND];
  int         m_polls [ND];
  int         m_nbusy [ND];
  logic [7:0] m_rv    [ND];
  logic [6:0] m_st    [ND];
  logic [7:0] m_last  [ND];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pin_id = 0;
  int rises [ND];
  bit e_prev [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_hd44780_ctrl #(.BUS_W(8), .T_AS(2), .T_PW(12), .T_H(2), .AUTO_BUSY(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wd[0]), .readdata(rdata[0]), .waitrequest(wreq[0]),
    .LCD_E(e[0]), .LCD_RS(rs[0]), .LCD_RW(rw[0]), .LCD_data(bus0));

  lcd_hd44780_ctrl #(.BUS_W(4), .T_AS(1), .T_PW(3), .T_H(1), .AUTO_BUSY(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wd[1]), .readdata(rdata[1]), .waitrequest(wreq[1]),
    .LCD_E(e[1]), .LCD_RS(rs[1]), .LCD_RW(rw[1]), .LCD_data(bus1));

  lcd_hd44780_ctrl #(.BUS_W(8), .T_AS(2), .T_PW(3), .T_H(1), .AUTO_BUSY(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wd[2]), .readdata(rdata[2]), .waitrequest(wreq[2]),
    .LCD_E(e[2]), .LCD_RS(rs[2]), .LCD_RW(rw[2]), .LCD_data(bus2));

  assign bus0 = pen[0] ? pval[0]      : 8'hzz;
  assign bus1 = pen[1] ? pval[1][3:0] : 4'hz;
  assign bus2 = pen[2] ? pval[2]      : 8'hzz;

  always_comb begin
    busv[0] = bus0;
    busv[1] = {4'h0, bus1};
    busv[2] = bus2;
  end

  function automatic int bw_of(input int k);  return (k == 1) ? 4 : 8;  endfunction
  function automatic int tas_of(input int k); return (k == 1) ? 1 : 2;  endfunction
  function automatic int tpw_of(input int k); return (k == 0) ? 12 : 3; endfunction
  function automatic int th_of(input int k);  return (k == 0) ? 2 : 1;  endfunction
  function automatic bit ab_of(input int k);  return (k == 2);          endfunction
  function automatic int p_of(input int k);   return tas_of(k) + tpw_of(k) + th_of(k); endfunction
  function automatic int nb_of(input int k);  return (bw_of(k) == 4) ? 2 : 1; endfunction

  // Expected pins for DUT k in cycle r of its current access (r = 0: request cycle)
  function automatic exp_t model(input int k, input int r);
    exp_t x;
    int   p, s, j, o, bi, ni;
    logic [7:0] b;
    x      = '0;
    x.busy = rd[k] | wr[k];
    b      = 8'h00;
    if (m_act[k] && r >= 0) begin
      p = p_of(k);
      s = nb_of(k) * (1 + m_polls[k]);
      if (r == s * p + 1) begin
        x.busy = 1'b0;
        x.done = 1'b1;
      end else if (r >= 1 && r <= s * p) begin
        j  = (r - 1) / p;
        o  = (r - 1) % p;
        bi = j / nb_of(k);
        ni = j % nb_of(k);
        x.e   = (o >= tas_of(k)) && (o < tas_of(k) + tpw_of(k));
        x.chk = 1'b1;
        if (bi == 0) begin
          x.rs = m_addr[k][1];
          x.rw = m_read[k];
        end else begin
          x.rs = 1'b0;
          x.rw = 1'b1;
        end
        if (bi == 0 && !m_read[k]) begin
          x.drv = 1'b1;
          b     = m_wd[k];
        end else if (bi == 0) begin
          b = m_rv[k];
        end else begin
          b = {((bi - 1) < m_nbusy[k]) ? 1'b1 : 1'b0, m_st[k]};
        end
        if (bw_of(k) == 4) b = (ni == 0) ? {4'h0, b[7:4]} : {4'h0, b[3:0]};
        if (x.drv) x.val = b;
        else if (x.e) x.pan = b;
      end
    end
    return x;
  endfunction

  // Panel: answers reads while E is high, otherwise holds the bus at zero
  // whenever the controller is not supposed to be driving it
  always_comb begin
    for (int k = 0; k < ND; k++) begin
      exp_t x;
      x       = model(k, cyc - m_start[k]);
      pen[k]  = !x.drv;
      pval[k] = x.pan;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT against the model
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      exp_t x;
      int   r;
      r = cyc - m_start[k];
      x = model(k, r);
      chk("E", k, 32'(e[k]), 32'(x.e));
      chk("WAITREQ", k, 32'(wreq[k]), 32'(x.busy));
      chk("BUS", k, 32'(busv[k]), 32'(x.drv ? x.val : x.pan));
      if (x.chk) begin
        chk("RS", k, 32'(rs[k]), 32'(x.rs));
        chk("RW", k, 32'(rw[k]), 32'(x.rw));
      end
      if (x.done) chk("RDATA", k, 32'(rdata[k]), 32'(m_read[k] ? m_rv[k] : m_last[k]));
      if (e[k] && !e_prev[k]) rises[k]++;
      e_prev[k] = e[k];
      // Hand-computed anchors for the model
      if (m_act[k] && pin_id == 1 && k == 0) begin
        if (r == 1)  chk("PIN_W41_BUS", k, 32'(busv[0]), 32'h41);
        if (r == 1)  chk("PIN_W41_RS", k, 32'(rs[0]), 32'h1);
        if (r == 2)  chk("PIN_W41_E2", k, 32'(e[0]), 32'h0);
        if (r == 3)  chk("PIN_W41_E3", k, 32'(e[0]), 32'h1);
        if (r == 14) chk("PIN_W41_E14", k, 32'(e[0]), 32'h1);
        if (r == 15) chk("PIN_W41_E15", k, 32'(e[0]), 32'h0);
        if (r == 17) chk("PIN_W41_DONE", k, 32'(wreq[0]), 32'h0);
      end
      if (m_act[k] && pin_id == 3 && k == 1) begin
        if (r == 1)  chk("PIN_N38_HI", k, 32'(busv[1]), 32'h3);
        if (r == 6)  chk("PIN_N38_LO", k, 32'(busv[1]), 32'h8);
        if (r == 11) chk("PIN_N38_DONE", k, 32'(wreq[1]), 32'h0);
      end
      if (m_act[k] && pin_id == 4 && k == 2) begin
        if (r == 30) chk("PIN_AB_BUSY30", k, 32'(wreq[2]), 32'h1);
        if (r == 31) chk("PIN_AB_DONE31", k, 32'(wreq[2]), 32'h0);
      end
    end
  end

  // One complete bus access on DUT k
  task automatic run(input int k, input bit r_, input bit w_, input logic [1:0] a,
                     input logic [7:0] d, input int nb, input logic [7:0] rv);
    int p, s, got;
    @(posedge clk); #1;
    rd[k] = r_; wr[k] = w_; addr[k] = a; wd[k] = d;
    m_read[k]  = r_;
    m_addr[k]  = a;
    m_wd[k]    = d;
    m_rv[k]    = rv;
    m_st[k]    = 7'($urandom);
    m_nbusy[k] = nb;
    m_polls[k] = (!r_ && ab_of(k)) ? nb + 1 : 0;
    m_start[k] = cyc;
    m_act[k]   = 1'b1;
    p   = p_of(k);
    s   = nb_of(k) * (1 + m_polls[k]);
    got = -1;
    for (int i = 0; i < s * p + 8; i++) begin
      @(negedge clk);
      if (wreq[k] === 1'b0) begin
        got = cyc - m_start[k];
        break;
      end
    end
    chk("LATENCY", k, 32'(got), 32'(s * p + 1));
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
    m_act[k] = 1'b0;
    if (r_) m_last[k] = rv;
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    for (int k = 0; k < ND; k++) begin
      rd[k] = 0; wr[k] = 0; addr[k] = 0; wd[k] = 0;
      m_act[k] = 0; m_start[k] = 0; m_read[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
      m_polls[k] = 0; m_nbusy[k] = 0; m_rv[k] = 0; m_st[k] = 0; m_last[k] = 0;
      rises[k] = 0; e_prev[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rd[0] = 1'b1;
    #1;
    chk("RST_WAITREQ_FOLLOWS", 0, 32'(wreq[0]), 32'h1);
    rd[0] = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("RST_E", k, 32'(e[k]), 32'h0);
      chk("RST_RS", k, 32'(rs[k]), 32'h0);
      chk("RST_RW", k, 32'(rw[k]), 32'h1);
      chk("RST_RDATA", k, 32'(rdata[k]), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // 8-bit directed accesses
    pin_id = 1;
    run(0, 1'b0, 1'b1, 2'b10, 8'h41, 0, 8'h00);
    pin_id = 0;
    run(0, 1'b1, 1'b0, 2'b11, 8'h00, 0, 8'hA5);
    chk("PIN_RD_A5", 0, 32'(rdata[0]), 32'hA5);
    run(0, 1'b1, 1'b1, 2'b01, 8'hFF, 0, 8'h3C);
    chk("PIN_RW_BOTH", 0, 32'(rdata[0]), 32'h3C);

    // 4-bit directed accesses
    pin_id = 3;
    run(1, 1'b0, 1'b1, 2'b00, 8'h38, 0, 8'h00);
    pin_id = 0;
    run(1, 1'b1, 1'b0, 2'b11, 8'h00, 0, 8'hC7);
    chk("PIN_RD_C7", 1, 32'(rdata[1]), 32'hC7);

    // Busy polling: BF held for three polls
    run(2, 1'b1, 1'b0, 2'b01, 8'h00, 0, 8'h5A);
    r0 = rises[2];
    pin_id = 4;
    run(2, 1'b0, 1'b1, 2'b10, 8'h80, 3, 8'h00);
    pin_id = 0;
    chk("PIN_AB_PULSES", 2, 32'(rises[2] - r0), 32'd5);
    chk("PIN_AB_RDATA", 2, 32'(rdata[2]), 32'h5A);

    // Reset in the middle of a pulse
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 2'b10; wd[0] = 8'h5C;
    m_read[0] = 0; m_addr[0] = 2'b10; m_wd[0] = 8'h5C; m_polls[0] = 0;
    m_start[0] = cyc; m_act[0] = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("PRE_RST_E", 0, 32'(e[0]), 32'h1);
    reset = 1'b1; wr[0] = 1'b0; m_act[0] = 1'b0;
    #1;
    chk("MIDRST_E", 0, 32'(e[0]), 32'h0);
    chk("MIDRST_BUS", 0, 32'(busv[0]), 32'h00);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < ND; k++) m_last[k] = 8'h00;
    chk("POSTRST_RS", 0, 32'(rs[0]), 32'h0);
    chk("POSTRST_RW", 0, 32'(rw[0]), 32'h1);
    chk("POSTRST_RDATA", 0, 32'(rdata[0]), 32'h0);
    run(0, 1'b0, 1'b1, 2'b00, 8'h01, 0, 8'h00);

    // Randomized accesses on every configuration
    for (int k = 0; k < ND; k++) begin
      for (int n = 0; n < 15; n++) begin
        int op;
        bit r_, w_;
        op = $urandom_range(0, 2);
        r_ = (op != 0);
        w_ = (op != 1);
        run(k, r_, w_, {1'($urandom), r_}, 8'($urandom), $urandom_range(0, 3), 8'($urandom));
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL WATCHDOG t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
